// File: rtl/rr_req_arbiter_pkg.sv
// rtl/rr_req_arbiter_pkg.sv - shared types and constants for the round-robin request arbiter
//
// Purpose: FSM state encoding, requester count, index width and a one-hot helper,
//          shared by the priority encoder and the arbiter top.
// Ports:   none (package).

package rr_req_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// rtl/rr_prio_enc4.sv - rotating 4-way priority encoder
//
// Purpose: picks the first active requester at or after ptr, wrapping around.
// Ports:
//   req    in  [3:0]  request vector, bit i is requester i
//   ptr    in  [1:0]  highest-priority requester index
//   winner out [1:0]  selected requester index (meaningless when any=0)
//   any    out        at least one request is active

module rr_prio_enc4
    import rr_req_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      idx;

    // Rotating right by ptr puts requester ptr at bit 0, so the fixed table
    // below always favours the pointer position first.
    assign dbl = {req, req};
    assign rot = dbl[{1'b0, ptr} +: NUM_REQ];

    always_comb begin
        idx = '0;
        casez (rot)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // 2-bit addition wraps, giving (idx + ptr) mod 4.
    assign winner = idx + ptr;
    assign any    = |req;

endmodule

// File: rtl/rr_req_arbiter.sv
// rtl/rr_req_arbiter.sv - 4-requester round-robin arbiter with hold limit and turnaround
//
// Purpose: grants one shared resource to one of four requesters, holds the grant
//          until done, request drop or the hold limit, and idles one cycle between grants.
// Ports:
//   clk       in        rising-edge clock
//   rst       in        synchronous active-high reset
//   req       in  [3:0] request vector
//   done      in        current holder releases the resource (used only while granting)
//   gnt       out [3:0] registered one-hot grant
//   gnt_id    out [1:0] binary index of the granted requester, valid with gnt_valid
//   gnt_valid out       a grant is asserted
//   timeout   out       one-cycle pulse after a grant is revoked by the hold limit

module rr_req_arbiter
    import rr_req_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [ID_W-1:0]    winner;
    logic               any;

    logic               rel_done;
    logic               rel_drop;
    logic               rel_limit;

    rr_prio_enc4 u_prio_enc (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    assign rel_done  = done;
    assign rel_drop  = ~req[gnt_id];
    assign rel_limit = (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state     <= GRANT;
                        gnt       <= id_to_onehot(winner);
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        ptr       <= winner + 2'd1;
                        hold_cnt  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (rel_done || rel_drop || rel_limit) begin
                        // Dropping to IDLE gives the mandatory empty turnaround
                        // cycle; gnt_id keeps its last value.
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        // A revocation only counts as a timeout when the holder
                        // had not already let go on the same edge.
                        timeout   <= rel_limit && !rel_done && !rel_drop;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb/tb_rr_req_arbiter.sv - self-checking bench for rr_req_arbiter

module tb_rr_req_arbiter;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       vld;
        logic       to;
        logic [1:0] id;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    step_t exp_q[$];

    rr_req_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic r, input logic [3:0] rq, input logic d,
                                 input logic [3:0] g, input logic v, input logic t,
                                 input logic [1:0] i);
        step_t s;
        s.rst = r; s.req = rq; s.done = d; s.gnt = g; s.vld = v; s.to = t; s.id = i;
        return s;
    endfunction

    task automatic test_reset();
        step_t tbl[$];
        step_t e;
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0, 0));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL reset step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL reset_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        step_t tbl[$];
        step_t e;
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 0, 2));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 0, 3));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 0));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL round_robin step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL round_robin_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        step_t tbl[$];
        step_t e;
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 0, 2));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 0, 4'b0010, 1, 0, 1));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL wrap_skip step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL wrap_skip_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    task automatic test_hold_limit();
        step_t tbl[$];
        step_t e;
        tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0, 2));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0, 2));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL hold_limit step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL hold_limit_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    task automatic test_request_drop();
        step_t tbl[$];
        step_t e;
        tbl.push_back(mk(1, 4'b1000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 1, 0, 3));
        tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 1, 0, 3));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL request_drop step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL request_drop_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        step_t tbl[$];
        step_t e;
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 0, 2));
        tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 1, 0, 0));
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req = tbl[k].req; done = tbl[k].done;
            exp_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to) begin
                errors++;
                $display("FAIL reset_mid_grant step %0d: gnt=%b valid=%b timeout=%b expected gnt=%b valid=%b timeout=%b",
                         k, gnt, gnt_valid, timeout, e.gnt, e.vld, e.to);
            end
            if (e.vld) begin
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL reset_mid_grant_id step %0d: gnt_id=%0d expected %0d", k, gnt_id, e.id);
                end
            end
        end
    endtask

    // Random traffic against a behavioural model that searches requesters in
    // pointer order rather than using a rotate-and-table encoder.
    task automatic test_random();
        logic       m_grant = 1'b0;
        logic [1:0] m_ptr   = 2'd0;
        int         m_cnt   = 0;
        logic [3:0] m_gnt   = 4'b0000;
        logic [1:0] m_id    = 2'd0;
        logic       m_to;
        logic [3:0] r;
        logic       d;
        logic       found;
        logic [1:0] c;
        step_t      e;

        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(posedge clk); #1;
        r = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            m_to = 1'b0;
            if (!m_grant) begin
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    c = m_ptr + 2'(j);
                    if (!found && r[c]) begin
                        found = 1'b1;
                        m_id  = c;
                    end
                end
                if (found) begin
                    m_grant = 1'b1;
                    m_gnt   = 4'b0001 << m_id;
                    m_ptr   = m_id + 2'd1;
                    m_cnt   = 1;
                end
            end else begin
                if (d || !r[m_id] || m_cnt == 4) begin
                    m_to    = (m_cnt == 4) && !d && r[m_id];
                    m_grant = 1'b0;
                    m_gnt   = 4'b0000;
                end else begin
                    m_cnt++;
                end
            end
            rst = 1'b0; req = r; done = d;
            exp_q.push_back(mk(0, r, d, m_gnt, m_grant, m_to, m_id));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.vld || timeout !== e.to || gnt_id !== e.id) begin
                errors++;
                $display("FAIL random cycle %0d: gnt=%b valid=%b timeout=%b id=%0d expected gnt=%b valid=%b timeout=%b id=%0d",
                         n, gnt, gnt_valid, timeout, gnt_id, e.gnt, e.vld, e.to, e.id);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_hold_limit();
        test_request_drop();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
